// File: rtl/degamma_pkg.sv
// Shared types and constants for the degamma LUT stage.
package degamma_pkg;

  localparam int LUT_DEPTH = 256;
  localparam int LUT_AW    = 8;
  localparam int PIPE_LAT  = 2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/degamma_lut_bank_ram.sv
// Two LUT banks: one shared write port (host or identity fill) and three
// registered read ports that all read the bank chosen by rd_bank.
module lut_bank_ram
  import degamma_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int PIX_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_we,
  input  logic [LUT_AW-1:0] init_addr,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [LUT_AW-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_bank,
  input  logic [LUT_AW-1:0] rd_addr_r,
  input  logic [LUT_AW-1:0] rd_addr_g,
  input  logic [LUT_AW-1:0] rd_addr_b,
  output logic [PIX_W-1:0]  rd_data_r,
  output logic [PIX_W-1:0]  rd_data_g,
  output logic [PIX_W-1:0]  rd_data_b
);

  logic [PIX_W-1:0] bank0_mem [DEPTH];
  logic [PIX_W-1:0] bank1_mem [DEPTH];

  logic [PIX_W-1:0] rd_r_d, rd_g_d, rd_b_d;
  logic [PIX_W-1:0] rd_r_q, rd_g_q, rd_b_q;

  // The identity fill owns both banks; host writes only land outside it.
  always_ff @(posedge clk) begin
    if (init_we) begin
      bank0_mem[init_addr] <= PIX_W'(init_addr);
      bank1_mem[init_addr] <= PIX_W'(init_addr);
    end else if (wr_en) begin
      if (wr_bank) begin
        bank1_mem[wr_addr] <= wr_data;
      end else begin
        bank0_mem[wr_addr] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_r_d = rd_bank ? bank1_mem[rd_addr_r] : bank0_mem[rd_addr_r];
    rd_g_d = rd_bank ? bank1_mem[rd_addr_g] : bank0_mem[rd_addr_g];
    rd_b_d = rd_bank ? bank1_mem[rd_addr_b] : bank0_mem[rd_addr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r_q <= '0;
      rd_g_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_r_q <= rd_r_d;
      rd_g_q <= rd_g_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_data_r = rd_r_q;
  assign rd_data_g = rd_g_q;
  assign rd_data_b = rd_b_q;

endmodule

// File: rtl/degamma_lut.sv
// Inverse-gamma stage for RGB888 video: a double-buffered programmable LUT
// with a two-cycle pipeline and frame-aligned bank swaps.
module degamma_lut
  import degamma_pkg::*;
#(
  parameter int LUT_DEPTH = 256,
  parameter int PIX_W     = 8,
  parameter bit VS_POL    = 1'b1
) (
  input  logic               video_clk,
  input  logic               rst_n,
  input  logic               video_de,
  input  logic               video_vs,
  input  logic [3*PIX_W-1:0] video_data,
  input  logic               cfg_we,
  input  logic [LUT_AW-1:0]  cfg_addr,
  input  logic [PIX_W-1:0]   cfg_data,
  input  logic               cfg_commit,
  output logic               degamma_de,
  output logic               degamma_vs,
  output logic [3*PIX_W-1:0] degamma_data,
  output logic               init_busy,
  output logic               swap_pending,
  output logic               bank_sel
);

  localparam logic [LUT_AW-1:0] INIT_LAST = LUT_AW'(LUT_DEPTH - 1);

  state_e            state_d, state_q;
  logic [LUT_AW-1:0] init_cnt_d, init_cnt_q;
  logic              bank_sel_d, bank_sel_q;
  logic              swap_pending_d, swap_pending_q;
  logic              init_busy_d, init_busy_q;

  logic               de_s1_d, de_s1_q;
  logic               vs_s1_d, vs_s1_q;
  logic [3*PIX_W-1:0] data_s1_d, data_s1_q;
  logic               de_s2_d, de_s2_q;
  logic               vs_s2_d, vs_s2_q;
  logic               bypass_d, bypass_q;
  logic [3*PIX_W-1:0] byp_data_d, byp_data_q;

  logic               vs_rise;
  logic [PIX_W-1:0]   lut_r, lut_g, lut_b;

  // Leading edge is judged against the stage-1 copy of vsync.
  assign vs_rise = (video_vs == VS_POL) && (vs_s1_q != VS_POL);

  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    bank_sel_d     = bank_sel_q;
    swap_pending_d = swap_pending_q;
    init_busy_d    = init_busy_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + LUT_AW'(1);
        if (init_cnt_q == INIT_LAST) begin
          state_d     = ST_RUN;
          init_busy_d = 1'b0;
          init_cnt_d  = '0;
        end
      end
      ST_RUN: begin
        if (cfg_commit) begin
          state_d        = ST_PEND;
          swap_pending_d = 1'b1;
        end
      end
      ST_PEND: begin
        if (vs_rise) begin
          state_d        = ST_RUN;
          bank_sel_d     = ~bank_sel_q;
          swap_pending_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_INIT;
      init_cnt_q     <= '0;
      bank_sel_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      init_busy_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      bank_sel_q     <= bank_sel_d;
      swap_pending_q <= swap_pending_d;
      init_busy_q    <= init_busy_d;
    end
  end

  // The bypass flag travels with stage 2 so pixels looked up while the
  // banks are still filling never see stale contents.
  always_comb begin
    de_s1_d    = video_de;
    vs_s1_d    = video_vs;
    data_s1_d  = video_data;
    de_s2_d    = de_s1_q;
    vs_s2_d    = vs_s1_q;
    bypass_d   = (state_q == ST_INIT);
    byp_data_d = data_s1_q;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      data_s1_q  <= '0;
      de_s2_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      bypass_q   <= 1'b1;
      byp_data_q <= '0;
    end else begin
      de_s1_q    <= de_s1_d;
      vs_s1_q    <= vs_s1_d;
      data_s1_q  <= data_s1_d;
      de_s2_q    <= de_s2_d;
      vs_s2_q    <= vs_s2_d;
      bypass_q   <= bypass_d;
      byp_data_q <= byp_data_d;
    end
  end

  lut_bank_ram #(
    .DEPTH (LUT_DEPTH),
    .PIX_W (PIX_W)
  ) u_ram (
    .clk       (video_clk),
    .rst_n     (rst_n),
    .init_we   (state_q == ST_INIT),
    .init_addr (init_cnt_q),
    .wr_en     (cfg_we && (state_q != ST_INIT)),
    .wr_bank   (~bank_sel_q),
    .wr_addr   (cfg_addr),
    .wr_data   (cfg_data),
    .rd_bank   (bank_sel_q),
    .rd_addr_r (data_s1_q[3*PIX_W-1:2*PIX_W]),
    .rd_addr_g (data_s1_q[2*PIX_W-1:PIX_W]),
    .rd_addr_b (data_s1_q[PIX_W-1:0]),
    .rd_data_r (lut_r),
    .rd_data_g (lut_g),
    .rd_data_b (lut_b)
  );

  always_comb begin
    degamma_data = bypass_q ? byp_data_q : {lut_r, lut_g, lut_b};
  end

  assign degamma_de   = de_s2_q;
  assign degamma_vs   = vs_s2_q;
  assign init_busy    = init_busy_q;
  assign swap_pending = swap_pending_q;
  assign bank_sel     = bank_sel_q;

endmodule

// File: tb/tb_degamma_lut.sv
// Directed and randomized checks of degamma_lut against a table-level model.
module tb_degamma_lut;
  import degamma_pkg::*;

  logic        video_clk = 1'b0;
  logic        rst_n;
  logic        video_de, video_vs;
  logic [23:0] video_data;
  logic        cfg_we, cfg_commit;
  logic [7:0]  cfg_addr, cfg_data;
  logic        degamma_de, degamma_vs;
  logic [23:0] degamma_data;
  logic        init_busy, swap_pending, bank_sel;

  always #5 video_clk = ~video_clk;

  degamma_lut #(
    .LUT_DEPTH (256),
    .PIX_W     (8),
    .VS_POL    (1'b1)
  ) dut (
    .video_clk    (video_clk),
    .rst_n        (rst_n),
    .video_de     (video_de),
    .video_vs     (video_vs),
    .video_data   (video_data),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_commit   (cfg_commit),
    .degamma_de   (degamma_de),
    .degamma_vs   (degamma_vs),
    .degamma_data (degamma_data),
    .init_busy    (init_busy),
    .swap_pending (swap_pending),
    .bank_sel     (bank_sel)
  );

  typedef struct packed {
    logic        de;
    logic        vs;
    logic [23:0] data;
  } pix_t;

  // Reference model: two tables, which one is live, and whether a swap is owed.
  pix_t       exp_q[$];
  logic [7:0] model_tbl [2][256];
  int         init_left;
  bit         model_active;
  bit         model_pending;
  bit         prev_vs;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         busy_cycles;
  bit         saved_bank;

  task automatic checkOutput(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] lookup(input bit b, input logic [23:0] d);
    return {model_tbl[b][d[23:16]], model_tbl[b][d[15:8]], model_tbl[b][d[7:0]]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 256; i++) begin
      model_tbl[0][i] = 8'(i);
      model_tbl[1][i] = 8'(i);
    end
    init_left     = LUT_DEPTH;
    model_active  = 1'b0;
    model_pending = 1'b0;
    prev_vs       = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // One pixel clock: drive inputs, advance the model, check after the edge.
  task automatic applyStimulus(input logic de, input logic vs, input logic [23:0] data,
                               input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic commit);
    pix_t e;
    bit   in_init;
    bit   vs_rise;
    video_de   = de;
    video_vs   = vs;
    video_data = data;
    cfg_we     = we;
    cfg_addr   = addr;
    cfg_data   = wdata;
    cfg_commit = commit;
    in_init = (init_left > 0);
    vs_rise = vs && !prev_vs;
    prev_vs = vs;
    if (in_init) begin
      init_left--;
    end else begin
      if (we) model_tbl[model_active ^ 1'b1][addr] = wdata;
      if (model_pending) begin
        if (vs_rise) begin
          model_active  = model_active ^ 1'b1;
          model_pending = 1'b0;
        end
      end else if (commit) begin
        model_pending = 1'b1;
      end
    end
    e.de   = de;
    e.vs   = vs;
    e.data = lookup(model_active, data);
    exp_q.push_back(e);
    @(posedge video_clk);
    #1;
    e = exp_q.pop_front();
    checkOutput("degamma_de", 24'(degamma_de), 24'(e.de));
    checkOutput("degamma_vs", 24'(degamma_vs), 24'(e.vs));
    checkOutput("degamma_data", degamma_data, e.data);
    checkOutput("bank_sel", 24'(bank_sel), 24'(model_active));
    checkOutput("swap_pending", 24'(swap_pending), 24'(model_pending));
    checkOutput("init_busy", 24'(init_busy), 24'(init_left > 0));
  endtask

  initial begin
    rst_n      = 1'b0;
    video_de   = 1'b0;
    video_vs   = 1'b0;
    video_data = '0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = '0;
    cfg_commit = 1'b0;
    repeat (3) @(posedge video_clk);
    #1;
    checkOutput("rst_de", 24'(degamma_de), 24'h0);
    checkOutput("rst_vs", 24'(degamma_vs), 24'h0);
    checkOutput("rst_data", degamma_data, 24'h0);
    checkOutput("rst_bank", 24'(bank_sel), 24'h0);
    checkOutput("rst_pending", 24'(swap_pending), 24'h0);
    checkOutput("rst_busy", 24'(init_busy), 24'h1);

    $display("[TB] identity fill and bypass");
    rst_n = 1'b1;
    modelReset();
    busy_cycles = 0;
    for (int c = 0; c < 270; c++) begin
      if (init_busy === 1'b1) busy_cycles++;
      if (c == 5 || c == 255)
        applyStimulus(1'b1, 1'b0, 24'h1080F0, 1'b1, 8'h10, 8'h55, 1'b1);
      else
        applyStimulus(1'b1, 1'b0, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b0);
      if (c == 0) checkOutput("bypass_first", degamma_data, 24'h000000);
      if (c == 1) checkOutput("bypass_2cyc", degamma_data, 24'h1080F0);
    end
    checkOutput("init_busy_len", 24'(busy_cycles), 24'd256);
    checkOutput("identity_after_init", degamma_data, 24'h1080F0);

    $display("[TB] load inverted shadow and commit");
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b0, 1'b0, 24'h1080F0, 1'b1, 8'(i), 8'(255 - i), 1'b0);
    applyStimulus(1'b1, 1'b0, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("commit_pending", 24'(swap_pending), 24'h1);
    checkOutput("commit_bank", 24'(bank_sel), 24'h0);
    repeat (4) applyStimulus(1'b1, 1'b0, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("pre_swap_data", degamma_data, 24'h1080F0);

    $display("[TB] vsync swap");
    applyStimulus(1'b1, 1'b1, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("swap_bank", 24'(bank_sel), 24'h1);
    checkOutput("swap_pending_clr", 24'(swap_pending), 24'h0);
    applyStimulus(1'b1, 1'b1, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("post_swap_data", degamma_data, 24'hEF7F0F);
    repeat (3) applyStimulus(1'b1, 1'b0, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b0);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 400; c++)
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                    24'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                    8'($urandom), ($urandom_range(0, 31) == 0));

    $display("[TB] commit coincident with vsync edge");
    repeat (2) applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    if (model_pending) begin
      applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    end
    saved_bank = model_active;
    applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("coinc_pending", 24'(swap_pending), 24'h1);
    checkOutput("coinc_no_swap", 24'(bank_sel), 24'(saved_bank));
    repeat (2) applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("coinc_hold_bank", 24'(bank_sel), 24'(saved_bank));
    applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("coinc_next_swap", 24'(bank_sel), 24'(saved_bank ^ 1'b1));
    checkOutput("coinc_next_clr", 24'(swap_pending), 24'h0);
    applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);

    $display("[TB] mid-frame reset");
    if (!model_active) begin
      applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b1);
      applyStimulus(1'b1, 1'b1, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
      applyStimulus(1'b1, 1'b0, 24'($urandom), 1'b0, 8'h00, 8'h00, 1'b0);
    end
    checkOutput("pre_reset_bank", 24'(bank_sel), 24'h1);
    repeat (3) applyStimulus(1'b1, 1'b1, 24'hFFFFFF, 1'b0, 8'h00, 8'h00, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_de", 24'(degamma_de), 24'h0);
    checkOutput("async_vs", 24'(degamma_vs), 24'h0);
    checkOutput("async_data", degamma_data, 24'h0);
    checkOutput("async_bank", 24'(bank_sel), 24'h0);
    checkOutput("async_pending", 24'(swap_pending), 24'h0);
    checkOutput("async_busy", 24'(init_busy), 24'h1);
    repeat (2) @(posedge video_clk);
    #1;
    rst_n = 1'b1;
    modelReset();
    for (int c = 0; c < 300; c++)
      applyStimulus(1'b1, ($urandom_range(0, 31) == 0), 24'($urandom), 1'b0,
                    8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 24'h1080F0, 1'b0, 8'h00, 8'h00, 1'b0);
    checkOutput("identity_after_reset", degamma_data, 24'h1080F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
